// File: rtl/tenthirty_pkg.sv
// Shared types and constants for the ten-and-a-half game: deck geometry,
// LFSR taps, the card-source state enum and its debug view.
package tenthirty_pkg;

  localparam int          DECK_SIZE = 52;
  localparam int          CARD_W    = 4;
  localparam int          MAX_VALUE = 13;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SHUFFLE = 2'd0,
    READY   = 2'd1,
    EMPTY   = 2'd2
  } deck_state_e;

  typedef struct packed {
    deck_state_e state;
    logic [5:0]  idx;
    logic [5:0]  ptr;
    logic [15:0] lfsr;
  } shuffler_dbg_t;

  // Smallest all-ones mask covering i, so a masked random draw lands in
  // [0, i] at least half the time.
  function automatic logic [5:0] span_mask(input logic [5:0] i);
    if (i > 6'd31)      return 6'h3F;
    else if (i > 6'd15) return 6'h1F;
    else if (i > 6'd7)  return 6'h0F;
    else if (i > 6'd3)  return 6'h07;
    else if (i > 6'd1)  return 6'h03;
    else                return 6'h01;
  endfunction

endpackage

// File: rtl/card_shuffler_if.sv
// Deal/status bus between the card source (slave) and the game controller (master).
interface card_shuffler_if;
  import tenthirty_pkg::*;

  // pip and shuffle are level requests sampled on every clock; there is no
  // ready handshake: a request seen while busy is dropped, never queued.
  logic          pip;
  logic          shuffle;
  logic [3:0]    number;
  logic          busy;
  logic          empty;
  logic [5:0]    cards_left;
  shuffler_dbg_t dbg;

  modport master (
    output pip, shuffle,
    input  number, busy, empty, cards_left, dbg
  );

  modport slave (
    input  pip, shuffle,
    output number, busy, empty, cards_left, dbg
  );

endinterface

// File: rtl/card_shuffler_lfsr16.sv
// 16-bit Galois LFSR with seed load; a zero seed is promoted to 1 so the
// register can never lock up.
module lfsr16
  import tenthirty_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = LFSR_TAPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_i,
  input  logic        load_i,
  output logic [15:0] state_o
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED_EFF;
    end else if (load_i) begin
      state_q <= SEED_EFF;
    end else if (step_i) begin
      state_q <= {1'b0, state_q[15:1]} ^ (state_q[0] ? TAPS : 16'h0000);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/card_shuffler.sv
// 52-card deck with in-place Fisher-Yates shuffle and one-card-per-cycle dealing.
module card_shuffler
  import tenthirty_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic             clk,
  input logic             rst_n,
  card_shuffler_if.slave  bus
);

  localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FULL     = 6'(DECK_SIZE);

  logic [15:0]       lfsr;
  deck_state_e       state_q;
  logic [CARD_W-1:0] deck_q [DECK_SIZE];
  logic [5:0]        idx_q;
  logic [5:0]        ptr_q;
  logic [CARD_W-1:0] number_q;
  logic              busy_q;
  logic              empty_q;
  logic [5:0]        left_q;

  logic [5:0]        cand_d;
  logic [5:0]        ptr_d;

  lfsr16 #(.SEED(SEED), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_i  (1'b1),
    .load_i  (1'b0),
    .state_o (lfsr)
  );

  assign cand_d = lfsr[5:0] & span_mask(idx_q);
  assign ptr_d  = ptr_q + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SHUFFLE;
      idx_q    <= LAST_IDX;
      ptr_q    <= '0;
      number_q <= '0;
      busy_q   <= 1'b1;
      empty_q  <= 1'b0;
      left_q   <= FULL;
      for (int n = 0; n < DECK_SIZE; n++) begin
        deck_q[n] <= CARD_W'((n % MAX_VALUE) + 1);
      end
    end else begin
      number_q <= '0;
      case (state_q)
        SHUFFLE: begin
          // A draw above i is rejected and retried with the next LFSR value.
          if (cand_d <= idx_q) begin
            deck_q[idx_q]  <= deck_q[cand_d];
            deck_q[cand_d] <= deck_q[idx_q];
            if (idx_q == 6'd1) begin
              ptr_q   <= '0;
              state_q <= READY;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q - 6'd1;
            end
          end
        end
        READY: begin
          if (bus.shuffle) begin
            state_q <= SHUFFLE;
            idx_q   <= LAST_IDX;
            busy_q  <= 1'b1;
            empty_q <= 1'b0;
            left_q  <= FULL;
          end else if (bus.pip) begin
            number_q <= deck_q[ptr_q];
            ptr_q    <= ptr_d;
            left_q   <= FULL - ptr_d;
            if (ptr_d == FULL) begin
              state_q <= EMPTY;
              empty_q <= 1'b1;
            end
          end
        end
        EMPTY: begin
          if (bus.shuffle) begin
            state_q <= SHUFFLE;
            idx_q   <= LAST_IDX;
            busy_q  <= 1'b1;
            empty_q <= 1'b0;
            left_q  <= FULL;
          end
        end
        default: begin
          state_q <= SHUFFLE;
          idx_q   <= LAST_IDX;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.number     = number_q;
  assign bus.busy       = busy_q;
  assign bus.empty      = empty_q;
  assign bus.cards_left = left_q;
  assign bus.dbg        = '{state: state_q, idx: idx_q, ptr: ptr_q, lfsr: lfsr};

endmodule

// File: tb/tb_card_shuffler.sv
// Bench for card_shuffler: a deck-level reference model (whole shuffle computed
// at once, deals popped from a queue) checked every cycle, plus directed scenarios.
module tb_card_shuffler;
  import tenthirty_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef logic [51:0][3:0] deck_t;

  typedef struct {
    bit         pre_wait;
    logic       pip;
    logic       shuf;
    logic       busy;
    logic       empty;
    logic [5:0] left;
    bit         nz;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic rst_z_n;
  always #5 clk = ~clk;

  card_shuffler_if bus   ();
  card_shuffler_if bus_z ();

  card_shuffler #(.SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  card_shuffler #(.SEED(16'h0000)) dut_z (
    .clk   (clk),
    .rst_n (rst_z_n),
    .bus   (bus_z)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    if (s % 2 == 1) return (s / 2) ^ 16'hB400;
    else            return s / 2;
  endfunction

  function automatic deck_t ordered_deck();
    deck_t d;
    for (int n = 0; n < 52; n++) d[n] = 4'((n % 13) + 1);
    return d;
  endfunction

  // Full Fisher-Yates pass from a given LFSR value; one draw per cycle.
  function automatic deck_t fisher_yates(input deck_t din, input logic [15:0] start,
                                         output int cycles);
    deck_t       d;
    logic [15:0] r;
    int          i, j, m;
    logic [3:0]  t;
    d = din; r = start; cycles = 0; i = 51;
    while (i >= 1) begin
      m = 1;
      while (m < i) m = m * 2 + 1;
      j = int'(r % 64) & m;
      r = lfsr_step(r);
      cycles++;
      if (j <= i) begin
        t = d[i]; d[i] = d[j]; d[j] = t;
        i--;
      end
    end
    return d;
  endfunction

  logic [15:0] m_lfsr;
  deck_t       m_deck;
  int          m_busy_cnt;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_number;
  logic        exp_busy;
  logic        exp_empty;
  logic [5:0]  exp_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr     = SEED;
      m_deck     = fisher_yates(ordered_deck(), m_lfsr, m_busy_cnt);
      exp_q.delete();
      exp_number = 4'd0;
      exp_busy   = 1'b1;
      exp_empty  = 1'b0;
      exp_left   = 6'd52;
    end else begin
      logic [15:0] nxt;
      int          c;
      nxt        = lfsr_step(m_lfsr);
      exp_number = 4'd0;
      if (m_busy_cnt > 0) begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) begin
          exp_busy = 1'b0;
          for (int n = 0; n < 52; n++) exp_q.push_back(m_deck[n]);
        end
      end else if (bus.shuffle) begin
        m_deck     = fisher_yates(m_deck, nxt, c);
        m_busy_cnt = c;
        exp_q.delete();
        exp_busy   = 1'b1;
        exp_empty  = 1'b0;
        exp_left   = 6'd52;
      end else if (bus.pip && exp_q.size() > 0) begin
        exp_number = exp_q.pop_front();
        exp_left   = 6'(exp_q.size());
        exp_empty  = (exp_q.size() == 0);
      end
      m_lfsr = nxt;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("model_number", int'(bus.number), int'(exp_number));
      check("model_busy", int'(bus.busy), int'(exp_busy));
      check("model_empty", int'(bus.empty), int'(exp_empty));
      check("model_cards_left", int'(bus.cards_left), int'(exp_left));
    end
  end

  logic [3:0] seq_z[$];
  always @(negedge clk) begin
    if (rst_z_n && bus_z.number != 4'd0 && seq_z.size() < 52) seq_z.push_back(bus_z.number);
  end

  // ---------------- drivers ----------------
  logic [3:0] seq_cur[$];
  logic [3:0] seq_a[$];

  task automatic cyc(input logic p, input logic s);
    bus.pip     = p;
    bus.shuffle = s;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    bus.pip     = 1'b0;
    bus.shuffle = 1'b0;
    while (bus.busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("shuffle_within_400", int'(bus.busy), 0);
  endtask

  task automatic deal_n(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b0);
      if (bus.number != 4'd0) seq_cur.push_back(bus.number);
    end
    bus.pip = 1'b0;
  endtask

  task automatic check_hist();
    int h[14];
    foreach (h[v]) h[v] = 0;
    foreach (seq_cur[k]) if (seq_cur[k] <= 4'd13) h[seq_cur[k]]++;
    check("cards_dealt", seq_cur.size(), 52);
    for (int v = 1; v <= 13; v++) check($sformatf("count_of_%0d", v), h[v], 4);
  endtask

  function automatic vec_t mk(bit w, logic p, logic s, logic b, logic e, logic [5:0] l, bit nz);
    vec_t r;
    r.pre_wait = w; r.pip = p; r.shuf = s; r.busy = b; r.empty = e; r.left = l; r.nz = nz;
    return r;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t  vt[11];
    deck_t z_exp;
    int    zc;

    vt[0]  = mk(0, 1, 0, 0, 1, 6'd0,  0);
    vt[1]  = mk(0, 0, 0, 0, 1, 6'd0,  0);
    vt[2]  = mk(0, 1, 0, 0, 1, 6'd0,  0);
    vt[3]  = mk(0, 0, 1, 1, 0, 6'd52, 0);
    vt[4]  = mk(0, 1, 0, 1, 0, 6'd52, 0);
    vt[5]  = mk(0, 0, 1, 1, 0, 6'd52, 0);
    vt[6]  = mk(1, 1, 0, 0, 0, 6'd51, 1);
    vt[7]  = mk(0, 1, 0, 0, 0, 6'd50, 1);
    vt[8]  = mk(0, 0, 0, 0, 0, 6'd50, 0);
    vt[9]  = mk(0, 1, 0, 0, 0, 6'd49, 1);
    vt[10] = mk(0, 0, 0, 0, 0, 6'd49, 0);

    bus.pip = 1'b0; bus.shuffle = 1'b0;
    bus_z.pip = 1'b0; bus_z.shuffle = 1'b0;
    rst_n = 1'b0; rst_z_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_number", int'(bus.number), 0);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_empty", int'(bus.empty), 0);
    check("rst_cards_left", int'(bus.cards_left), 52);

    rst_n = 1'b1; rst_z_n = 1'b1; chk_en = 1'b1;
    bus_z.pip = 1'b1;

    // pip 5 cycles into the shuffle must be dropped
    repeat (4) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("pip_in_shuffle_number", int'(bus.number), 0);
    wait_ready();
    check("left_after_shuffle", int'(bus.cards_left), 52);

    seq_cur.delete();
    deal_n(52);
    check_hist();
    check("empty_after_52", int'(bus.empty), 1);
    check("left_after_52", int'(bus.cards_left), 0);
    seq_a = seq_cur;

    // over-deal, reshuffle from EMPTY, requests during shuffle, then dealing
    for (int k = 0; k < 11; k++) begin
      if (vt[k].pre_wait) wait_ready();
      cyc(vt[k].pip, vt[k].shuf);
      check($sformatf("vec%0d_busy", k), int'(bus.busy), int'(vt[k].busy));
      check($sformatf("vec%0d_empty", k), int'(bus.empty), int'(vt[k].empty));
      check($sformatf("vec%0d_left", k), int'(bus.cards_left), int'(vt[k].left));
      check($sformatf("vec%0d_number_nz", k), int'(bus.number != 4'd0), int'(vt[k].nz));
    end

    // simultaneous pip + shuffle at 40 cards left
    deal_n(9);
    check("left_before_simul", int'(bus.cards_left), 40);
    cyc(1'b1, 1'b1);
    check("simul_number", int'(bus.number), 0);
    check("simul_busy", int'(bus.busy), 1);
    check("simul_left", int'(bus.cards_left), 52);
    wait_ready();
    check("simul_left_done", int'(bus.cards_left), 52);
    seq_cur.delete();
    deal_n(52);
    check_hist();

    // reset 20 cycles into a shuffle must match a clean reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cyc(1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    wait_ready();
    seq_cur.delete();
    deal_n(52);
    check("reset_seq_len", seq_cur.size(), 52);
    for (int k = 0; k < 52; k++) begin
      if (k < seq_cur.size() && k < seq_a.size())
        check($sformatf("reset_seq_%0d", k), int'(seq_cur[k]), int'(seq_a[k]));
    end

    // randomized traffic against the model
    repeat (3000) begin
      cyc(1'(($urandom_range(0, 99) < 70) ? 1 : 0), 1'(($urandom_range(0, 99) < 2) ? 1 : 0));
    end
    cyc(1'b0, 1'b0);

    // SEED = 0 instance must deal the SEED = 1 permutation
    z_exp = fisher_yates(ordered_deck(), 16'h0001, zc);
    check("seed0_seq_len", seq_z.size(), 52);
    for (int k = 0; k < 52; k++) begin
      if (k < seq_z.size()) check($sformatf("seed0_seq_%0d", k), int'(seq_z[k]), int'(z_exp[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/card_shuffler.md
# card_shuffler

Card source for the ten-and-a-half game. It sits directly upstream of the game controller and drives the controller's `number` input from its `pip` request. It holds a 52-card deck (values 1–13, four of each) and shuffles it in hardware with a Fisher-Yates pass driven by an LFSR. It then deals one card per request without repeats until the deck runs out or is reshuffled.

## Interface
Parameters:
- SEED, 16'hACE1, LFSR seed. A value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  block clock; same divided control clock as the game controller.
- rst_n  input  1  reset, asynchronous, active-low.
- pip  input  1  deal request, level-sampled; one card per cycle while high and READY.
- shuffle  input  1  reshuffle request, sampled each cycle.
- number  output  4  dealt card value 1–13 for one cycle; 0 otherwise.
- busy  output  1  high while the shuffle is in progress.
- empty  output  1  high when all 52 cards have been dealt.
- cards_left  output  6  undealt card count, 0–52.

## Operation
- Deck storage: 52 × 4-bit entries plus a 6-bit deal pointer `ptr`.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Advances every cycle, free-running, independent of state.
  - Loads SEED on reset.
- States:
  - SHUFFLE:
    - Index `i` runs from 51 down to 1.
    - `m` = smallest 2^k−1 ≥ i. Candidate `j` = lfsr[5:0] & m.
    - If j ≤ i: swap deck[i] and deck[j], then decrement i.
    - If j > i: reject; no swap, i unchanged, retry next cycle.
    - After the swap at i = 1: ptr ← 0, go to READY.
  - READY:
    - pip = 1: number ← deck[ptr], ptr ← ptr+1.
    - If ptr becomes 52: go to EMPTY.
  - EMPTY:
    - pip is ignored; number stays 0.
- Transitions out of reset: reset loads the deck in order (entry n = (n mod 13)+1) and enters SHUFFLE directly.
- Requests during SHUFFLE: pip and shuffle are both ignored; no card is dealt and no request is queued.
- Reshuffle:
  - shuffle = 1 in READY or EMPTY: go to SHUFFLE with i = 51.
  - The shuffle permutes the current deck contents, which always remain the full 52-card multiset.
  - ptr resets to 0 when the shuffle completes.
- Simultaneous pip and shuffle in READY: shuffle wins; no card is dealt; ptr is unchanged.
- cards_left = 52 − ptr. It reads 52 throughout SHUFFLE.

## Timing
- All outputs are registered.
- Reset values: number = 0, busy = 1, empty = 0, cards_left = 52.
- Deal latency: pip sampled high at edge N → number is valid during cycle N+1 → number returns to 0 at edge N+2 unless pip is still high and cards remain.
- Back-to-back dealing: pip held high for k cycles deals k consecutive cards on consecutive cycles, subject to the deck limit.
- Shuffle length:
  - Minimum 51 cycles.
  - Acceptance per attempt is ≥ 50%, so the expected length is ≤ 102 cycles.
  - The bench bound is 400 cycles.
- Status update timing:
  - busy falls on the same edge that enters READY.
  - empty rises on the edge that deals card 52.
- Reset mid-operation: reset is asynchronous. It reloads the ordered deck, reloads the LFSR and restarts SHUFFLE; any partial permutation is discarded.

## Structure
- Shared package tenthirty_pkg holds:
  - DECK_SIZE = 52, CARD_W = 4, MAX_VALUE = 13.
  - LFSR_TAPS = 16'hB400.
  - A state enum of {SHUFFLE, READY, EMPTY}, also usable by the game controller for debug display.
- Sub-module lfsr16: step, seed load, 16-bit state output. Used here and reusable elsewhere in the game.
- The deck is a register array. No RAM inference is required, because the swap needs two reads and two writes in the same cycle.

## Test plan
- Deck completeness: reset, wait for busy = 0, hold pip for 52 cycles. Each value 1–13 must appear exactly 4 times on number, cards_left must count down to 0, and empty = 1 after the 52nd card.
- Over-deal: with the deck empty, pulse pip once. number must stay 0, empty must stay 1 and cards_left must stay 0.
- Request during shuffle: pulse pip 5 cycles after reset. number must stay 0 and cards_left must stay 52 after READY is reached.
- Simultaneous requests: in READY with cards_left = 40, assert pip and shuffle in the same cycle. No card is dealt, busy = 1 on the next cycle, cards_left = 52 after completion, and a full deal again yields 4 of each value.
- Reset mid-shuffle: assert rst_n = 0 at shuffle cycle 20, then release. The card sequence must equal that of a clean reset with identical pip timing.
- Determinism and seeds: the same SEED with the same stimulus gives an identical 52-card sequence. SEED = 0 must behave identically to SEED = 1. The number output must be nonzero only in cycles that directly follow a dealt pip.
